// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and defaults shared by the data-memory arbiter
package arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_USR  = 2'b01,
    ARB_ACK  = 2'b10
  } arb_state_e;
  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_W       = 4;
endpackage

// File: rtl/MUX21.sv
// MUX21: two-input multiplexer, sel=1 picks d1
module MUX21 #(
  parameter int W = 1
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at MAX, with priority clear
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU and a user port,
// stalling the CPU for the single cycle the user port owns the memory
module dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_ack,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        state_q, state_d;
  logic              usr_ack_q, usr_ack_d;
  logic [DATA_W-1:0] usr_rdata_q, usr_rdata_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant, is_usr, cnt_clr, cnt_inc, cpu_mem_we;
  always_comb begin
    grant       = usr_req && (!cpu_req || wait_cnt == WAIT_W'(MAX_WAIT));
    is_usr      = state_q == ARB_USR;
    state_d     = is_usr ? ARB_ACK : (state_q == ARB_IDLE && grant) ? ARB_USR : ARB_IDLE;
    cnt_clr     = !usr_req || (state_q == ARB_IDLE && grant);
    cnt_inc     = state_q == ARB_IDLE && usr_req && cpu_req;
    cpu_mem_we  = cpu_req & cpu_we;
    usr_ack_d   = is_usr;
    usr_rdata_d = is_usr ? mem_rdata : usr_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      usr_ack_q   <= 1'b0;
      usr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      usr_ack_q   <= usr_ack_d;
      usr_rdata_q <= usr_rdata_d;
    end
  end
  sat_counter #(.W(WAIT_W), .MAX(MAX_WAIT)) u_wait (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(cnt_inc), .cnt(wait_cnt)
  );
  MUX21 #(.W(ADDR_W)) u_mux_addr (.d0(cpu_addr),   .d1(usr_addr),  .sel(is_usr), .y(mem_addr));
  MUX21 #(.W(DATA_W)) u_mux_wdat (.d0(cpu_wdata),  .d1(usr_wdata), .sel(is_usr), .y(mem_wdata));
  MUX21 #(.W(1))      u_mux_we   (.d0(cpu_mem_we), .d1(usr_we),    .sel(is_usr), .y(mem_we));
  assign cpu_stall = is_usr & cpu_req;
  assign cpu_rdata = mem_rdata;
  assign usr_ack   = usr_ack_q;
  assign usr_rdata = usr_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MW = 4;
  logic clk = 0, rst_n = 0;
  logic cpu_req = 0, cpu_we = 0, usr_req = 0, usr_we = 0;
  logic [AW-1:0] cpu_addr = '0, usr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, usr_wdata = '0;
  logic [DW-1:0] cpu_rdata, usr_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic cpu_stall, usr_ack, mem_we;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  int n_vec = 0, n_err = 0;
  int phase = 0, waited = 0;
  logic exp_ack = 0;
  logic [DW-1:0] exp_urd = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_ack(usr_ack), .usr_rdata(usr_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  // Transaction model: phase 0 arbitrating, 1 user owns memory, 2 ack cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; waited = 0; exp_ack = 0; exp_urd = '0;
    end else begin
      exp_ack = (phase == 1);
      if (phase == 1) begin
        exp_urd = ref_mem[usr_addr[7:0]];
        if (usr_we) ref_mem[usr_addr[7:0]] = usr_wdata;
      end else if (cpu_req && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      if (phase == 1) phase = 2;
      else if (phase == 2) phase = 0;
      else if (usr_req && (!cpu_req || waited == MW)) begin phase = 1; waited = 0; end
      else if (usr_req && cpu_req) waited = (waited < MW) ? waited + 1 : MW;
      if (!usr_req) waited = 0;
    end
  end

  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; usr_req = 0; usr_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h5;
    #1;
    n_vec += 4;
    if (usr_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", usr_ack); end
    if (usr_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", usr_rdata); end
    if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    if (mem_we !== 1'b1 || mem_addr !== 32'h8) begin n_err++; $display("FAIL reset_mux we=%b addr=%h exp we=1 addr=8", mem_we, mem_addr); end
    idle_inputs();
    next(); next();
    rst_n = 1;
    next();
  endtask

  task automatic test_uncontended_write();
    usr_req = 1; usr_we = 1; usr_addr = 32'h10; usr_wdata = 32'hA5;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec += 2;
      if (mem_we !== (c == 1)) begin n_err++; $display("FAIL wr_mem_we c=%0d got=%b exp=%b", c, mem_we, c == 1); end
      if (usr_ack !== (c == 2)) begin n_err++; $display("FAIL wr_ack c=%0d got=%b exp=%b", c, usr_ack, c == 2); end
      if (c == 2) usr_req = 0;
      next();
    end
    n_vec++;
    if (mem[8'h10] !== 32'hA5) begin n_err++; $display("FAIL wr_mem got=%h exp=a5", mem[8'h10]); end
  endtask

  task automatic test_uncontended_read();
    usr_req = 1; usr_we = 0; usr_addr = 32'h10;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_vec++;
      if (usr_ack !== (c == 2)) begin n_err++; $display("FAIL rd_ack c=%0d got=%b exp=%b", c, usr_ack, c == 2); end
      if (c >= 2) begin
        n_vec++;
        if (usr_rdata !== 32'hA5) begin n_err++; $display("FAIL rd_data c=%0d got=%h exp=a5", c, usr_rdata); end
      end
      if (c == 2) usr_req = 0;
      next();
    end
  endtask

  task automatic test_starvation();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    usr_req = 1; usr_we = 0; usr_addr = 32'h10;
    for (int c = 0; c < 9; c++) begin
      #1;
      n_vec += 2;
      if (cpu_stall !== (c == 5)) begin n_err++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, cpu_stall, c == 5); end
      if (usr_ack !== (c == 6)) begin n_err++; $display("FAIL starve_ack c=%0d got=%b exp=%b", c, usr_ack, c == 6); end
      if (c >= 1 && c <= 4) begin
        n_vec++;
        if (dut.wait_cnt !== 4'(c)) begin n_err++; $display("FAIL starve_cnt c=%0d got=%0d exp=%0d", c, dut.wait_cnt, c); end
      end
      if (c == 6) usr_req = 0;
      next();
    end
    idle_inputs();
    next();
  endtask

  task automatic test_conflict();
    mem[8'h20] = 32'h11; ref_mem[8'h20] = 32'h11;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; cpu_wdata = 32'h33;
    usr_req = 1; usr_we = 0; usr_addr = 32'h20;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) cpu_we = 1;
      #1;
      if (c == 5) begin
        n_vec += 2;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL conf_usr we=%b stall=%b exp we=0 stall=1", mem_we, cpu_stall); end
        if (mem_addr !== 32'h20) begin n_err++; $display("FAIL conf_addr got=%h exp=20", mem_addr); end
      end
      if (c == 6) begin
        n_vec += 2;
        if (usr_ack !== 1'b1 || usr_rdata !== 32'h11) begin n_err++; $display("FAIL conf_rdata ack=%b got=%h exp=11", usr_ack, usr_rdata); end
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL conf_cpuwr we=%b stall=%b exp we=1 stall=0", mem_we, cpu_stall); end
        usr_req = 0;
      end
      if (c == 7) begin
        n_vec++;
        if (mem[8'h20] !== 32'h33) begin n_err++; $display("FAIL conf_mem got=%h exp=33", mem[8'h20]); end
        idle_inputs();
      end
      next();
    end
  endtask

  task automatic test_reset_in_usr();
    usr_req = 1; usr_we = 0; usr_addr = 32'h10;
    next();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h77;
    #1;
    n_vec++;
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstu_pre we=%b exp=0", mem_we); end
    #2 rst_n = 0;
    #1;
    n_vec += 2;
    if (mem_we !== 1'b1 || mem_addr !== 32'h30) begin n_err++; $display("FAIL rstu_mux we=%b addr=%h exp we=1 addr=30", mem_we, mem_addr); end
    if (usr_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL rstu_out ack=%b stall=%b exp 0 0", usr_ack, cpu_stall); end
    cpu_req = 0; cpu_we = 0;
    next();
    #1;
    n_vec++;
    if (usr_ack !== 1'b0) begin n_err++; $display("FAIL rstu_noack got=%b exp=0", usr_ack); end
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (usr_ack !== (c == 2)) begin n_err++; $display("FAIL rstu_ack c=%0d got=%b exp=%b", c, usr_ack, c == 2); end
      if (c == 2) usr_req = 0;
      next();
    end
  endtask

  task automatic test_back_to_back();
    usr_req = 1; usr_we = 0; usr_addr = 32'h10;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_vec++;
      if (usr_ack !== (c == 2 || c == 5)) begin n_err++; $display("FAIL b2b_ack c=%0d got=%b exp=%b", c, usr_ack, c == 2 || c == 5); end
      if (c == 5) usr_req = 0;
      next();
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ew, es;
    for (int c = 0; c < 600; c++) begin
      cpu_req = $urandom_range(0, 3) != 0; cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
      if (phase == 2 && $urandom_range(0, 1) == 1) usr_req = 0;
      else if ((phase == 2 || !usr_req) && $urandom_range(0, 2) == 0) begin
        usr_req = 1; usr_we = $urandom_range(0, 1) == 1;
        usr_addr = AW'($urandom_range(0, 15)); usr_wdata = $urandom;
      end
      #1;
      ea = (phase == 1) ? usr_addr : cpu_addr;
      ed = (phase == 1) ? usr_wdata : cpu_wdata;
      ew = (phase == 1) ? usr_we : (cpu_req & cpu_we);
      es = (phase == 1) & cpu_req;
      n_vec += 5;
      if (mem_addr !== ea || mem_wdata !== ed || mem_we !== ew) begin
        n_err++; $display("FAIL rnd_mem c=%0d got=%h/%h/%b exp=%h/%h/%b", c, mem_addr, mem_wdata, mem_we, ea, ed, ew);
      end
      if (cpu_stall !== es) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, cpu_stall, es); end
      if (usr_ack !== exp_ack) begin n_err++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, usr_ack, exp_ack); end
      if (usr_rdata !== exp_urd) begin n_err++; $display("FAIL rnd_urd c=%0d got=%h exp=%h", c, usr_rdata, exp_urd); end
      if (cpu_rdata !== ref_mem[ea[7:0]]) begin n_err++; $display("FAIL rnd_crd c=%0d got=%h exp=%h", c, cpu_rdata, ref_mem[ea[7:0]]); end
      next();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i * 3 + 1); ref_mem[i] = 32'(i * 3 + 1);
    end
    @(negedge clk);
    test_reset();
    test_uncontended_write();
    test_uncontended_read();
    test_starvation();
    test_conflict();
    test_reset_in_usr();
    next(); next();
    test_back_to_back();
    next(); next();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-cycle CPU's data memory port between two requesters.
- The CPU load/store path is the primary requester. The user/debug I/O port is the secondary requester.
- The block sits between the datapath (ALU address, register read-data 2, MemWrite) and the DataMemory instance.
- It stalls the PC when the user port takes a memory cycle. A starvation counter guarantees the user port eventually gets access.

Parameters:
- ADDR_W, 32, width of the address on all ports.
- DATA_W, 32, width of the data on all ports.
- MAX_WAIT, 4, number of consecutive contended cycles the user port waits before being forced a grant; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_req  in  1  CPU needs memory this cycle (MemWrite or load).
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address (ALU output).
- cpu_wdata  in  DATA_W  CPU write data (RD2).
- cpu_rdata  out  DATA_W  read data to the CPU write-back mux.
- cpu_stall  out  1  holds the PC and blocks register-file writes.
- usr_req  in  1  user request; held with its fields stable until usr_ack.
- usr_we  in  1  user write enable.
- usr_addr  in  ADDR_W  user address.
- usr_wdata  in  DATA_W  user write data.
- usr_ack  out  1  one-cycle completion pulse.
- usr_rdata  out  DATA_W  registered user read data, valid when usr_ack=1 and held until the next ack.
- mem_we  out  1  to DataMemory (synchronous write).
- mem_addr  out  ADDR_W  to DataMemory.
- mem_wdata  out  DATA_W  to DataMemory.
- mem_rdata  in  DATA_W  from DataMemory (combinational read).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait_cnt=0, usr_ack=0, usr_rdata=0.
  - Outputs follow the IDLE muxing below, so cpu_stall=0.
- States:
  - IDLE: CPU owns the port.
  - USR: user owns the port for exactly one cycle.
  - ACK: CPU owns the port; usr_ack=1.
- IDLE -> USR when usr_req && (!cpu_req || wait_cnt==MAX_WAIT). Otherwise stay in IDLE.
- USR -> ACK unconditionally.
- ACK -> IDLE unconditionally. No grant decision is made in ACK.
- wait_cnt:
  - In IDLE with usr_req && cpu_req && wait_cnt<MAX_WAIT: increments at the edge. It saturates at MAX_WAIT.
  - Cleared on the edge entering USR.
  - Cleared whenever usr_req=0.
- Muxing in IDLE and ACK:
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we, cpu_stall=0.
- Muxing in USR:
  - mem_addr=usr_addr, mem_wdata=usr_wdata, mem_we=usr_we, cpu_stall=cpu_req.
  - The CPU write is suppressed.
- cpu_rdata=mem_rdata at all times (combinational; meaningful only when not stalled).
- User data capture: at the edge leaving USR, usr_rdata<=mem_rdata and usr_ack<=1. usr_ack<=0 at every other edge.
  - For a user write, usr_rdata captures the pre-write content.
- Latency:
  - Uncontended: usr_req sampled high at cycle 0 -> USR in cycle 1 -> usr_ack in cycle 2.
  - Contended: worst case is MAX_WAIT+2 cycles to ack.
- Back-to-back user requests: if usr_req is still high in the cycle after ack, it is treated as a new transaction.
- cpu_req rising while in USR: stalled exactly for that cycle; the CPU access completes in ACK.
- Reset mid-operation: the pending user transaction is dropped with no ack. If usr_req remains high, it is re-arbitrated after reset.
- No combinational path from usr_* to usr_ack.

Decomposition:
- Shared package (arb_pkg):
  - State encoding constants: ARB_IDLE=2'b00, ARB_USR=2'b01, ARB_ACK=2'b10.
  - Default MAX_WAIT.
- One sub-module: sat_counter (saturating up-counter with clear and max parameter), used for wait_cnt.
- Muxes reuse the existing MUX21 module.

Test Plan:
- Uncontended write: cpu_req=0; usr_req=1, usr_we=1, addr=0x10, wdata=0xA5 at cycle 0 -> mem_we=1 only in cycle 1; usr_ack=1 only in cycle 2; mem[0x10]=0xA5.
- Uncontended read: after the write above, usr_we=0, addr=0x10 -> usr_rdata=0xA5 with ack at cycle 2; usr_rdata holds until the next ack.
- Starvation: cpu_req=1 every cycle, usr_req at cycle 0, MAX_WAIT=4 ->
  - wait_cnt goes 1,2,3,4;
  - USR (cpu_stall=1) only in cycle 5;
  - ack in cycle 6;
  - cpu_stall=0 in all other cycles.
- Same-address conflict: CPU write 0x33 and user read at 0x20 (initial 0x11), user forced grant -> usr_rdata=0x11; the CPU write lands in the ACK cycle; mem[0x20]=0x33 afterwards.
- Reset in USR: rst_n=0 mid-cycle 1 -> usr_ack stays 0; mem_we follows the CPU immediately; state=IDLE; after release with usr_req still high, ack arrives 2 cycles later.
- Back-to-back: usr_req held high through ack -> second ack exactly 3 cycles after the first with cpu_req=0.
